// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan receiver: active-low glyph patterns and FSM state codes.
// Latency: n/a (constants only). Backpressure: n/a.
// Type glyph_t is the decoder result bundle.
package seg7_pkg;

    // abcdefg, active-low: [6]=a ... [0]=g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef struct packed {
        logic       valid;
        logic       blank;
        logic [3:0] nibble;
    } glyph_t;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Maps an active-low abcdefg pattern to {valid, blank, nibble}; blank is not a valid glyph.
// Latency: combinational. Backpressure: none.
// Reusable by the encoder side for self-checks.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output glyph_t     glyph_o
);

    always_comb begin
        glyph_o = '{valid: 1'b1, blank: 1'b0, nibble: 4'h0};
        case (seg_i)
            SEG_0:     glyph_o.nibble = 4'h0;
            SEG_1:     glyph_o.nibble = 4'h1;
            SEG_2:     glyph_o.nibble = 4'h2;
            SEG_3:     glyph_o.nibble = 4'h3;
            SEG_4:     glyph_o.nibble = 4'h4;
            SEG_5:     glyph_o.nibble = 4'h5;
            SEG_6:     glyph_o.nibble = 4'h6;
            SEG_7:     glyph_o.nibble = 4'h7;
            SEG_8:     glyph_o.nibble = 4'h8;
            SEG_9:     glyph_o.nibble = 4'h9;
            SEG_A:     glyph_o.nibble = 4'hA;
            SEG_B:     glyph_o.nibble = 4'hB;
            SEG_C:     glyph_o.nibble = 4'hC;
            SEG_D:     glyph_o.nibble = 4'hD;
            SEG_E:     glyph_o.nibble = 4'hE;
            SEG_F:     glyph_o.nibble = 4'hF;
            SEG_BLANK: begin
                glyph_o.valid = 1'b0;
                glyph_o.blank = 1'b1;
            end
            default:   glyph_o.valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Watches a scanned 7-seg bus, waits for each slot to settle, decodes it into the digit word.
// Latency: SETTLE_CYCLES+2 edges from first stable input edge to digit_valid. Backpressure: none, pulses only.
// Optional SEG_ERR_COUNT_EN adds a saturating err_count output.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    mclk,
    input  logic                    clr,
    input  logic [NUM_DIGITS-1:0]   AN,
    input  logic [6:0]              a_to_g,
    input  logic                    dp,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp_vec,
    output logic                    digit_valid,
    output logic                    frame_valid,
    output logic                    seg_err,
    output logic                    an_err
`ifdef SEG_ERR_COUNT_EN
    ,
    output logic [7:0]              err_count
`endif
);

    localparam int            CW      = $clog2(SETTLE_CYCLES + 1);
    localparam int            IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES);

    logic [NUM_DIGITS-1:0]   an_s1_q, an_cap_q, seen_q, seen_d, dp_vec_q, dp_vec_d;
    logic [6:0]              seg_s1_q, seg_cap_q;
    logic                    dp_s1_q, dp_cap_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              state_q, state_d;
    logic                    an_err_done_q, an_err_done_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic                    digit_valid_q, frame_valid_q, seg_err_q, an_err_q;

    logic                    s1_change, an_none, an_one, an_multi;
    logic [NUM_DIGITS-1:0]   an_low;
    logic                    an_err_set, take_sample, write_en, bad_glyph, frame_full;
    logic [IW-1:0]           cap_idx;
    glyph_t                  glyph;

    seg7_glyph_decode u_glyph (
        .seg_i   (seg_cap_q),
        .glyph_o (glyph)
    );

    assign s1_change = (AN != an_s1_q) || (a_to_g != seg_s1_q) || (dp != dp_s1_q);
    assign cnt_d     = s1_change ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1));

    assign an_low   = ~an_s1_q;
    assign an_none  = (an_low == '0);
    assign an_one   = !an_none && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
    assign an_multi = !an_none && !an_one;

    // Capture works from the snapshot taken on SETTLE exit, so an input edge
    // coinciding with that exit cannot corrupt the decoded slot.
    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_cap_q[i]) cap_idx = IW'(i);
        end
    end

    always_comb begin
        state_d     = state_q;
        an_err_set  = 1'b0;
        take_sample = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (an_one) begin
                    state_d = ST_SETTLE;
                end else if (an_multi && cnt_q == CNT_MAX && !an_err_done_q) begin
                    an_err_set = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!an_one) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d     = ST_CAPTURE;
                    take_sample = 1'b1;
                end
            end
            ST_CAPTURE: state_d = ST_HOLD;
            ST_HOLD: begin
                if (an_s1_q != an_cap_q) begin
                    state_d = ST_IDLE;
                end else if (seg_s1_q != seg_cap_q || dp_s1_q != dp_cap_q) begin
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign an_err_done_d = s1_change ? 1'b0 : (an_err_done_q | an_err_set);
    assign write_en      = (state_q == ST_CAPTURE) && glyph.valid;
    assign bad_glyph     = (state_q == ST_CAPTURE) && !glyph.valid && !glyph.blank;
    assign frame_full    = &seen_q;

    always_comb begin
        digits_d = digits_q;
        dp_vec_d = dp_vec_q;
        seen_d   = frame_full ? '0 : seen_q;
        if (write_en) begin
            digits_d[4*cap_idx +: 4] = glyph.nibble;
            dp_vec_d[cap_idx]        = ~dp_cap_q;
            seen_d[cap_idx]          = 1'b1;
        end
    end

    always_ff @(posedge mclk) begin
        if (clr) begin
            an_s1_q       <= '1;
            seg_s1_q      <= SEG_BLANK;
            dp_s1_q       <= 1'b1;
            an_cap_q      <= '1;
            seg_cap_q     <= SEG_BLANK;
            dp_cap_q      <= 1'b1;
            cnt_q         <= '0;
            state_q       <= ST_IDLE;
            an_err_done_q <= 1'b0;
            digits_q      <= '0;
            dp_vec_q      <= '0;
            seen_q        <= '0;
            digit_valid_q <= 1'b0;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            an_s1_q       <= AN;
            seg_s1_q      <= a_to_g;
            dp_s1_q       <= dp;
            if (take_sample) begin
                an_cap_q  <= an_s1_q;
                seg_cap_q <= seg_s1_q;
                dp_cap_q  <= dp_s1_q;
            end
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            an_err_done_q <= an_err_done_d;
            digits_q      <= digits_d;
            dp_vec_q      <= dp_vec_d;
            seen_q        <= seen_d;
            digit_valid_q <= write_en;
            frame_valid_q <= frame_full;
            seg_err_q     <= bad_glyph;
            an_err_q      <= an_err_set;
        end
    end

`ifdef SEG_ERR_COUNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Counts on the same edge the error pulse registers; coincident errors add one.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((bad_glyph || an_err_set) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge mclk) begin
        if (clr) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`endif

    assign digits      = digits_q;
    assign dp_vec      = dp_vec_q;
    assign digit_valid = digit_valid_q;
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign an_err      = an_err_q;

endmodule
